// File: rtl/mips_control_unit_if.sv
// rtl/mips_control_unit_if.sv - decoded instruction fields in, branch offset and halt status out
interface mips_control_unit_if;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rs_num;
    logic [4:0]  rt_num;
    logic [4:0]  rd_num;
    logic [4:0]  sh_amount;
    logic [15:0] imm;
    logic [31:0] pc_branch;
    logic        halted_signal;

    modport master (
        output opcode, func, rs_num, rt_num, rd_num, sh_amount, imm,
        input  pc_branch, halted_signal
    );

    modport slave (
        input  opcode, func, rs_num, rt_num, rd_num, sh_amount, imm,
        output pc_branch, halted_signal
    );
endinterface

// File: rtl/mips_control_unit.sv
// rtl/mips_control_unit.sv - single-cycle MIPS execute/control block with 32x32 register file
module mips_control_unit (
    input logic               clk,
    input logic               rst_b,
    mips_control_unit_if.slave bus
);
    logic [31:0] regs [32];
    logic        halted;

    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] sext_imm;
    logic [31:0] zext_imm;
    logic [31:0] branch_off;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        is_syscall;
    logic        taken;

    // $0 is hard-wired to zero regardless of array contents; reads see pre-edge values
    always_comb begin
        rs_val     = (bus.rs_num == 5'd0) ? 32'd0 : regs[bus.rs_num];
        rt_val     = (bus.rt_num == 5'd0) ? 32'd0 : regs[bus.rt_num];
        sext_imm   = {{16{bus.imm[15]}}, bus.imm};
        zext_imm   = {16'd0, bus.imm};
        branch_off = {sext_imm[29:0], 2'b00} + 32'd4;
    end

    // Decode: pick destination and result; unrecognised encodings leave wr_en low
    always_comb begin
        wr_en      = 1'b0;
        wr_addr    = 5'd0;
        wr_data    = 32'd0;
        is_syscall = 1'b0;
        if (bus.opcode == 6'h00) begin
            wr_addr = bus.rd_num;
            wr_en   = 1'b1;
            case (bus.func)
                6'h20, 6'h21: wr_data = rs_val + rt_val;
                6'h22, 6'h23: wr_data = rs_val - rt_val;
                6'h24:        wr_data = rs_val & rt_val;
                6'h25:        wr_data = rs_val | rt_val;
                6'h26:        wr_data = rs_val ^ rt_val;
                6'h27:        wr_data = ~(rs_val | rt_val);
                6'h2A:        wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
                6'h2B:        wr_data = {31'd0, rs_val < rt_val};
                6'h00:        wr_data = rt_val << bus.sh_amount;
                6'h02:        wr_data = rt_val >> bus.sh_amount;
                6'h03:        wr_data = $unsigned($signed(rt_val) >>> bus.sh_amount);
                6'h04:        wr_data = rt_val << rs_val[4:0];
                6'h06:        wr_data = rt_val >> rs_val[4:0];
                6'h07:        wr_data = $unsigned($signed(rt_val) >>> rs_val[4:0]);
                6'h0C: begin
                    wr_en      = 1'b0;
                    is_syscall = 1'b1;
                end
                default:      wr_en = 1'b0;
            endcase
        end else begin
            wr_addr = bus.rt_num;
            wr_en   = 1'b1;
            case (bus.opcode)
                6'h08, 6'h09: wr_data = rs_val + sext_imm;
                6'h0A:        wr_data = {31'd0, $signed(rs_val) < $signed(sext_imm)};
                6'h0B:        wr_data = {31'd0, rs_val < sext_imm};
                6'h0C:        wr_data = rs_val & zext_imm;
                6'h0D:        wr_data = rs_val | zext_imm;
                6'h0E:        wr_data = rs_val ^ zext_imm;
                6'h0F:        wr_data = {bus.imm, 16'd0};
                default:      wr_en = 1'b0;
            endcase
        end
    end

    // Branch redirect is combinational; suppressed while in reset or after halt
    always_comb begin
        taken = ((bus.opcode == 6'h04) && (rs_val == rt_val)) ||
                ((bus.opcode == 6'h05) && (rs_val != rt_val));
        bus.pc_branch     = (!rst_b || halted || !taken) ? 32'd0 : branch_off;
        bus.halted_signal = halted;
    end

    // Register write-back and sticky halt flag; halt freezes all architectural state
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            halted <= 1'b0;
        end else if (!halted) begin
            if (wr_en && (wr_addr != 5'd0)) begin
                regs[wr_addr] <= wr_data;
            end
            if (is_syscall) begin
                halted <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mips_control_unit.sv
// tb/tb_mips_control_unit.sv - scoreboard bench for mips_control_unit
module tb_mips_control_unit;
    logic clk = 1'b0;
    logic rst_b = 1'b0;

    mips_control_unit_if bus ();

    mips_control_unit dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_halt;
        logic [31:0] exp;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   halted_model = 1'b0;

    function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    task automatic drive(input logic [31:0] inst);
        bus.opcode    = inst[31:26];
        bus.rs_num    = inst[25:21];
        bus.rt_num    = inst[20:16];
        bus.rd_num    = inst[15:11];
        bus.sh_amount = inst[10:6];
        bus.func      = inst[5:0];
        bus.imm       = inst[15:0];
    endtask

    task automatic push(input string name, input logic [31:0] exp_pc);
        exp_t e;
        e.name = {name, ".pc_branch"}; e.is_halt = 1'b0; e.exp = exp_pc;
        expq.push_back(e);
        e.name = {name, ".halted"}; e.is_halt = 1'b1; e.exp = {31'd0, halted_model};
        expq.push_back(e);
    endtask

    // One instruction per cycle: drive just after the rising edge, expectations to the scoreboard
    task automatic issue(input string name, input logic [31:0] inst, input logic [31:0] exp_pc);
        @(posedge clk);
        #1;
        drive(inst);
        push(name, exp_pc);
        if (inst[31:26] == 6'h00 && inst[5:0] == 6'h0C) halted_model = 1'b1;
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        while (expq.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = expq.pop_front();
            act = e.is_halt ? {31'd0, bus.halted_signal} : bus.pc_branch;
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // reset: a would-be taken beq must still give 0
        drive(itype(6'h04, 5'd0, 5'd0, 16'd1));
        push("reset", 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_b = 1'b1;

        // 1. basic addi and branches
        issue("addi1",  itype(6'h08, 5'd0, 5'd1, 16'd5), 32'd0);
        issue("beq_nt", itype(6'h04, 5'd1, 5'd0, 16'd3), 32'd0);
        issue("bne_t",  itype(6'h05, 5'd1, 5'd0, 16'd3), 32'd16);

        // 2. wrap-around and signed/unsigned compare
        issue("addi2",  itype(6'h08, 5'd0, 5'd2, 16'hFFFF), 32'd0);
        issue("addiu3", itype(6'h09, 5'd0, 5'd3, 16'd1), 32'd0);
        issue("addu4",  rtype(6'h21, 5'd2, 5'd3, 5'd4, 5'd0), 32'd0);
        issue("wrap",   itype(6'h04, 5'd4, 5'd0, 16'd1), 32'd8);
        issue("slt5",   rtype(6'h2A, 5'd2, 5'd3, 5'd5, 5'd0), 32'd0);
        issue("slt_chk",  itype(6'h04, 5'd5, 5'd3, 16'd1), 32'd8);
        issue("sltu5",  rtype(6'h2B, 5'd2, 5'd3, 5'd5, 5'd0), 32'd0);
        issue("sltu_chk", itype(6'h04, 5'd5, 5'd3, 16'd1), 32'd0);

        // 3. shifts
        issue("lui6",   itype(6'h0F, 5'd0, 5'd6, 16'h8000), 32'd0);
        issue("sra7",   rtype(6'h03, 5'd0, 5'd6, 5'd7, 5'd4), 32'd0);
        issue("lui8a",  itype(6'h0F, 5'd0, 5'd8, 16'hF800), 32'd0);
        issue("sra_chk",  itype(6'h04, 5'd7, 5'd8, 16'd1), 32'd8);
        issue("srl7",   rtype(6'h02, 5'd0, 5'd6, 5'd7, 5'd4), 32'd0);
        issue("lui8b",  itype(6'h0F, 5'd0, 5'd8, 16'h0800), 32'd0);
        issue("srl_chk",  itype(6'h04, 5'd7, 5'd8, 16'd1), 32'd8);
        issue("sllv7",  rtype(6'h04, 5'd3, 5'd6, 5'd7, 5'd0), 32'd0);
        issue("sllv_chk", itype(6'h04, 5'd7, 5'd0, 16'd1), 32'd8);

        // extra ALU coverage
        issue("sub9",   rtype(6'h22, 5'd3, 5'd2, 5'd9, 5'd0), 32'd0);
        issue("addi10", itype(6'h08, 5'd0, 5'd10, 16'd2), 32'd0);
        issue("sub_chk",  itype(6'h04, 5'd9, 5'd10, 16'd1), 32'd8);
        issue("nor9",   rtype(6'h27, 5'd0, 5'd0, 5'd9, 5'd0), 32'd0);
        issue("nor_chk",  itype(6'h04, 5'd9, 5'd2, 16'd1), 32'd8);
        issue("sltiu9", itype(6'h0B, 5'd3, 5'd9, 16'hFFFF), 32'd0);
        issue("sltiu_chk", itype(6'h04, 5'd9, 5'd3, 16'd1), 32'd8);
        issue("ori9",   itype(6'h0D, 5'd0, 5'd9, 16'hFFFF), 32'd0);
        issue("ori_chk",  itype(6'h05, 5'd9, 5'd2, 16'd1), 32'd8);

        // 4. $0 protection and negative offsets
        issue("addi0",  itype(6'h08, 5'd0, 5'd0, 16'd7), 32'd0);
        issue("zero_chk", itype(6'h05, 5'd0, 5'd0, 16'd3), 32'd0);
        issue("beq_m2", itype(6'h04, 5'd0, 5'd0, 16'hFFFE), 32'hFFFF_FFFC);
        issue("beq_m1", itype(6'h04, 5'd0, 5'd0, 16'hFFFF), 32'd0);

        // 5. syscall halts everything
        issue("syscall", rtype(6'h0C, 5'd0, 5'd0, 5'd0, 5'd0), 32'd0);
        issue("h_addi", itype(6'h08, 5'd0, 5'd1, 16'd9), 32'd0);
        issue("h_bne",  itype(6'h05, 5'd1, 5'd0, 16'd3), 32'd0);
        issue("h_beq",  itype(6'h04, 5'd0, 5'd0, 16'd1), 32'd0);

        // 6. asynchronous reset between edges clears halt immediately
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        halted_model = 1'b0;
        drive(itype(6'h04, 5'd0, 5'd0, 16'd1));
        push("async_rst", 32'd0);
        @(posedge clk);
        #1 rst_b = 1'b1;
        push("post_rst", 32'd8);
        issue("regs1_clr", itype(6'h05, 5'd1, 5'd0, 16'd3), 32'd0);
        issue("regs2_clr", itype(6'h05, 5'd2, 5'd0, 16'd3), 32'd0);

        @(negedge clk);
        @(posedge clk);
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
